// File: rtl/prewish5k_pkg.sv
// Shared types and constants for the prewish5k blink-mask sequencer.
package prewish5k_pkg;

   localparam int DATA_W    = 8;
   localparam int PAT_COUNT = 4;
   localparam int IDX_W     = $clog2(PAT_COUNT);

   localparam logic [DATA_W-1:0] PAT0 = 8'hA0;
   localparam logic [DATA_W-1:0] PAT1 = 8'hF0;
   localparam logic [DATA_W-1:0] PAT2 = 8'hAA;
   localparam logic [DATA_W-1:0] PAT3 = 8'h80;

   typedef enum logic [1:0] {
      ST_START,
      ST_WRITE,
      ST_HOLD
   } state_e;

   function automatic logic [DATA_W-1:0] pattern_at(input logic [IDX_W-1:0] idx);
      logic [DATA_W-1:0] pat;
      case (idx)
         2'd0:    pat = PAT0;
         2'd1:    pat = PAT1;
         2'd2:    pat = PAT2;
         default: pat = PAT3;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/prewish5k_holdtimer.sv
// Pattern hold counter: counts while enabled, clear wins over enable,
// tc_o is registered and high during the cycle the count sits at all ones.
module prewish5k_holdtimer #(
   parameter int HOLD_BITS = 26
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [HOLD_BITS-1:0] ONES    = '1;
   localparam logic [HOLD_BITS-1:0] LAST_M1 = ONES - HOLD_BITS'(1);

   logic [HOLD_BITS-1:0] cnt_q, cnt_d;
   logic                 tc_q, tc_d;

   always_comb begin
      cnt_d = cnt_q;
      tc_d  = tc_q;
      if (clr_i) begin
         cnt_d = '0;
         tc_d  = 1'b0;
      end else if (en_i) begin
         cnt_d = cnt_q + HOLD_BITS'(1);
         // Look one count ahead so tc lines up with the all-ones cycle.
         tc_d  = (cnt_q == LAST_M1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
      end
   end

   assign tc_o = tc_q;

endmodule

// File: rtl/prewish5k_sequencer.sv
// Wishbone single-write initiator cycling four blink masks into the blinky.
// Optional full ACK handshake with timeout and sticky error: PREWISH_SEQ_ACK_EN.
module prewish5k_sequencer
   import prewish5k_pkg::*;
#(
   parameter int HOLD_BITS   = 26,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic              CLK_I,
   input  logic              RST_N_I,
   input  logic              i_advance,
   input  logic              ACK_I,
   output logic              CYC_O,
   output logic              STB_O,
   output logic [7:0]        DAT_O,
   output logic [1:0]        o_index,
   output logic              o_err
);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   dat_q, dat_d;
   logic                stb_q, stb_d;
   logic                hold_clr, hold_en, hold_tc;
   logic                write_done;

   prewish5k_holdtimer #(
      .HOLD_BITS (HOLD_BITS)
   ) u_holdtimer (
      .clk_i  (CLK_I),
      .rst_ni (RST_N_I),
      .clr_i  (hold_clr),
      .en_i   (hold_en),
      .tc_o   (hold_tc)
   );

`ifdef PREWISH_SEQ_ACK_EN
   logic [7:0] to_q, to_d;
   logic       err_q, err_d;
   logic       timed_out;

   always_comb begin
      timed_out  = (state_q == ST_WRITE) && !ACK_I && (to_q == 8'(ACK_TIMEOUT - 1));
      write_done = ACK_I || timed_out;
      to_d       = ((state_q == ST_WRITE) && !write_done) ? to_q + 8'd1 : 8'd0;
      err_d      = err_q | timed_out;
   end

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         to_q  <= 8'd0;
         err_q <= 1'b0;
      end else begin
         to_q  <= to_d;
         err_q <= err_d;
      end
   end

   assign o_err = err_q;
`else
   logic ack_unused;
   assign ack_unused = ACK_I & (ACK_TIMEOUT > 0);
   assign write_done = 1'b1;
   assign o_err      = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      dat_d    = dat_q;
      stb_d    = 1'b0;
      hold_clr = 1'b1;
      hold_en  = 1'b0;
      case (state_q)
         ST_START: state_d = ST_WRITE;
         ST_WRITE: if (write_done) state_d = ST_HOLD;
         ST_HOLD: begin
            hold_en  = 1'b1;
            hold_clr = 1'b0;
            // Terminal count and advance together still make one step.
            if (hold_tc || i_advance) begin
               idx_d    = idx_q + IDX_W'(1);
               hold_clr = 1'b1;
               state_d  = ST_WRITE;
            end
         end
         default: state_d = ST_START;
      endcase
      // Bus outputs are registered from the next state.
      if (state_d == ST_WRITE) begin
         stb_d = 1'b1;
         dat_d = pattern_at(idx_d);
      end
   end

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         state_q <= ST_START;
         idx_q   <= '0;
         dat_q   <= '0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dat_q   <= dat_d;
         stb_q   <= stb_d;
      end
   end

   assign CYC_O   = stb_q;
   assign STB_O   = stb_q;
   assign DAT_O   = dat_q;
   assign o_index = idx_q;

endmodule
